// File: rtl/serial_alu_ctrl_if.sv
// ---------------------------------------------------------------------------
// serial_alu_ctrl_if
// Request/response bundle between the EX stage (master) and the bit-serial
// ALU controller (slave).
//   start   : request, accepted only while the controller is idle
//   abort   : synchronous cancel of an in-flight operation
//   alu_op  : 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
//   op_a/b  : operands, sampled on the accept edge
//   busy    : operation in progress
//   done    : one-cycle completion pulse
//   result  : result word, stable from done until the next accept
//   zero    : result == 0
//   ovf     : signed overflow (ADD/SUB only)
//   op_err  : unsupported alu_op, valid with done
// ---------------------------------------------------------------------------
interface serial_alu_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             abort;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             ovf;
  logic             op_err;

  modport master (
    output start, abort, alu_op, op_a, op_b,
    input  busy, done, result, zero, ovf, op_err
  );

  modport slave (
    input  start, abort, alu_op, op_a, op_b,
    output busy, done, result, zero, ovf, op_err
  );
endinterface

// File: rtl/serial_alu_ctrl.sv
// ---------------------------------------------------------------------------
// serial_alu_ctrl
// Drives a single external 1-bit ALU slice bit-serially (LSB first) for WIDTH
// cycles to execute one AND/OR/ADD/SUB/SLT on WIDTH-bit operands.
// Ports:
//   clk, rst        : rising-edge clock, asynchronous active-high reset
//   ex              : request/response bundle (slave side), see the interface
//   slice_a/b/cin   : operand bits and carry-in for the current bit
//   slice_binvert   : invert b inside the slice (SUB/SLT)
//   slice_sel       : slice result mux (0 AND, 1 OR, 2 SUM, 3 LESS)
//   slice_less      : less input of the slice, tied low
//   slice_out       : slice result bit
//   slice_cout      : slice carry out
//   slice_set       : slice adder sum bit (sign of the difference at the MSB)
// ---------------------------------------------------------------------------
module serial_alu_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  serial_alu_ctrl_if.slave ex,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  output logic             slice_binvert,
  output logic [1:0]       slice_sel,
  output logic             slice_less,
  input  logic             slice_out,
  input  logic             slice_cout,
  input  logic             slice_set
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    SLT_FIX,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [CNT_W-1:0] cnt;
  logic             carry_q;
  logic [1:0]       sel_q;
  logic             binvert_q;
  logic             is_slt_q;
  logic             is_arith_q;
  logic             set_msb_q;
  logic             ovf_sub_q;
  // An unsupported op is reported one cycle after acceptance; this flag holds
  // the controller in IDLE (ignoring start) for that cycle.
  logic             err_pend;

  // Op decode
  logic             dec_legal;
  logic [1:0]       dec_sel;
  logic             dec_binvert;

  always_comb begin
    dec_legal   = 1'b1;
    dec_sel     = 2'd0;
    dec_binvert = 1'b0;
    case (ex.alu_op)
      3'b000: dec_sel = 2'd0;
      3'b001: dec_sel = 2'd1;
      3'b010: dec_sel = 2'd2;
      3'b110: begin dec_sel = 2'd2; dec_binvert = 1'b1; end
      3'b111: begin dec_sel = 2'd2; dec_binvert = 1'b1; end
      default: dec_legal = 1'b0;
    endcase
  end

  // Slice drive: derived from registers, forced low outside RUN
  logic run;
  assign run           = (state == RUN);
  assign slice_a       = run & a_sh[0];
  assign slice_b       = run & b_sh[0];
  assign slice_cin     = run & ((cnt == '0) ? binvert_q : carry_q);
  assign slice_binvert = run & binvert_q;
  assign slice_sel     = run ? sel_q : 2'd0;
  assign slice_less    = 1'b0;

  // Next result word once the current slice bit is shifted in at the MSB
  logic [WIDTH-1:0] res_next;
  assign res_next = {slice_out, res_sh[WIDTH-1:1]};

  // Signed overflow at the MSB: carry into the sign bit differs from carry out
  logic msb_ovf;
  assign msb_ovf = slice_cin ^ slice_cout;

  // Signed less-than = sign of the difference corrected by overflow
  logic slt_bit;
  assign slt_bit = set_msb_q ^ ovf_sub_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      a_sh       <= '0;
      b_sh       <= '0;
      res_sh     <= '0;
      cnt        <= '0;
      carry_q    <= 1'b0;
      sel_q      <= 2'd0;
      binvert_q  <= 1'b0;
      is_slt_q   <= 1'b0;
      is_arith_q <= 1'b0;
      set_msb_q  <= 1'b0;
      ovf_sub_q  <= 1'b0;
      err_pend   <= 1'b0;
      ex.busy    <= 1'b0;
      ex.done    <= 1'b0;
      ex.result  <= '0;
      ex.zero    <= 1'b1;
      ex.ovf     <= 1'b0;
      ex.op_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ex.done <= 1'b0;
          if (err_pend) begin
            err_pend  <= 1'b0;
            state     <= DONE;
            ex.done   <= 1'b1;
            ex.result <= '0;
            ex.zero   <= 1'b1;
            ex.ovf    <= 1'b0;
            ex.op_err <= 1'b1;
          end else if (ex.start) begin
            // start wins over a simultaneous abort here
            if (dec_legal) begin
              a_sh       <= ex.op_a;
              b_sh       <= ex.op_b;
              sel_q      <= dec_sel;
              binvert_q  <= dec_binvert;
              is_slt_q   <= (ex.alu_op == 3'b111);
              is_arith_q <= (ex.alu_op == 3'b010) || (ex.alu_op == 3'b110);
              cnt        <= '0;
              carry_q    <= 1'b0;
              state      <= RUN;
              ex.busy    <= 1'b1;
            end else begin
              err_pend <= 1'b1;
            end
          end
        end

        RUN: begin
          if (ex.abort) begin
            state   <= IDLE;
            ex.busy <= 1'b0;
          end else begin
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            res_sh  <= res_next;
            carry_q <= slice_cout;
            cnt     <= cnt + 1'b1;
            if (cnt == LAST_BIT) begin
              if (is_slt_q) begin
                set_msb_q <= slice_set;
                ovf_sub_q <= msb_ovf;
                state     <= SLT_FIX;
              end else begin
                state     <= DONE;
                ex.busy   <= 1'b0;
                ex.done   <= 1'b1;
                ex.result <= res_next;
                ex.zero   <= (res_next == '0);
                ex.ovf    <= is_arith_q & msb_ovf;
                ex.op_err <= 1'b0;
              end
            end
          end
        end

        SLT_FIX: begin
          ex.busy <= 1'b0;
          if (ex.abort) begin
            state <= IDLE;
          end else begin
            res_sh    <= {{(WIDTH-1){1'b0}}, slt_bit};
            state     <= DONE;
            ex.done   <= 1'b1;
            ex.result <= {{(WIDTH-1){1'b0}}, slt_bit};
            ex.zero   <= ~slt_bit;
            ex.ovf    <= 1'b0;
            ex.op_err <= 1'b0;
          end
        end

        DONE: begin
          // start is deliberately ignored here; the requester retries in IDLE
          ex.done <= 1'b0;
          state   <= IDLE;
        end

        default: begin
          state   <= IDLE;
          ex.busy <= 1'b0;
          ex.done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_alu_ctrl.sv
module tb_serial_alu_ctrl;

  localparam int WIDTH = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       slice_a, slice_b, slice_cin, slice_binvert, slice_less;
  logic [1:0] slice_sel;
  logic       slice_out, slice_cout, slice_set;

  int vec_cnt = 0;
  int err_cnt = 0;

  serial_alu_ctrl_if #(.WIDTH(WIDTH)) ex_if ();

  serial_alu_ctrl #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk           (clk),
    .rst           (rst),
    .ex            (ex_if),
    .slice_a       (slice_a),
    .slice_b       (slice_b),
    .slice_cin     (slice_cin),
    .slice_binvert (slice_binvert),
    .slice_sel     (slice_sel),
    .slice_less    (slice_less),
    .slice_out     (slice_out),
    .slice_cout    (slice_cout),
    .slice_set     (slice_set)
  );

  always #5 clk = ~clk;

  // Behavioural 1-bit ALU slice
  logic       bb;
  logic [1:0] add2;
  always_comb begin
    bb         = slice_b ^ slice_binvert;
    add2       = {1'b0, slice_a} + {1'b0, bb} + {1'b0, slice_cin};
    slice_cout = add2[1];
    slice_set  = add2[0];
    case (slice_sel)
      2'd0:    slice_out = slice_a & bb;
      2'd1:    slice_out = slice_a | bb;
      2'd2:    slice_out = add2[0];
      default: slice_out = slice_less;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Applies one op and checks the completion; poke>0 pulses a stray start
  // that many cycles into the run.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_ovf,
                        input logic exp_err, input int exp_lat,
                        input bit with_abort, input int poke);
    int lat;
    logic [1:0] exp_sel;
    exp_sel = (op == 3'b000) ? 2'd0 : (op == 3'b001) ? 2'd1 : 2'd2;
    @(negedge clk);
    ex_if.start  = 1'b1;
    ex_if.abort  = with_abort;
    ex_if.alu_op = op;
    ex_if.op_a   = a;
    ex_if.op_b   = b;
    @(posedge clk);
    #1;
    ex_if.start = 1'b0;
    ex_if.abort = 1'b0;
    if (!exp_err) begin
      chk({tag, "_busy"}, ex_if.busy, 1);
      chk({tag, "_sel"}, slice_sel, exp_sel);
      chk({tag, "_cin0"}, slice_cin, (op == 3'b110 || op == 3'b111));
    end
    lat = 0;
    while (!ex_if.done && lat < 200) begin
      @(posedge clk);
      lat++;
      #1;
      if (lat == poke) begin
        ex_if.start  = 1'b1;
        ex_if.alu_op = 3'b000;
        ex_if.op_a   = '0;
        ex_if.op_b   = '0;
      end else begin
        ex_if.start = 1'b0;
      end
    end
    ex_if.start = 1'b0;
    chk({tag, "_done"}, ex_if.done, 1);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_res"}, ex_if.result, exp_res);
    chk({tag, "_zero"}, ex_if.zero, (exp_res == 0));
    chk({tag, "_ovf"}, ex_if.ovf, exp_ovf);
    chk({tag, "_err"}, ex_if.op_err, exp_err);
    $display("op %s alu_op=%b a=%h b=%h -> result=%h ovf=%b err=%b lat=%0d",
             tag, op, a, b, ex_if.result, ex_if.ovf, ex_if.op_err, lat);
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, ex_if.done, 0);
    chk({tag, "_held"}, ex_if.result, exp_res);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, ex_if.busy, 0);
    chk({tag, "_done"}, ex_if.done, 0);
    chk({tag, "_res"}, ex_if.result, 0);
    chk({tag, "_zero"}, ex_if.zero, 1);
    chk({tag, "_ovf"}, ex_if.ovf, 0);
    chk({tag, "_err"}, ex_if.op_err, 0);
    chk({tag, "_slice"}, {slice_a, slice_b, slice_cin, slice_binvert, slice_sel, slice_less}, 0);
  endtask

  initial begin
    int n, first_done, second_done;
    bit seen;
    ex_if.start  = 1'b0;
    ex_if.abort  = 1'b0;
    ex_if.alu_op = 3'b000;
    ex_if.op_a   = '0;
    ex_if.op_b   = '0;

    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst_hold");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_vals("rst_rel");
    $display("reset checked");

    run_op("add_ovf", 3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1, 0, 32, 0, 0);
    run_op("sub_zero", 3'b110, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 0, 0, 32, 0, 0);
    run_op("sub_ovf", 3'b110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1, 0, 32, 0, 0);
    run_op("slt_neg", 3'b111, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0001, 0, 0, 33, 0, 0);
    run_op("slt_ovf", 3'b111, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 0, 0, 33, 0, 0);
    run_op("and", 3'b000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 0, 0, 32, 0, 0);
    run_op("or", 3'b001, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 0, 0, 32, 0, 0);

    // Abort at cnt=20 of an ADD, with a stray start on the same cycle
    @(negedge clk);
    ex_if.start  = 1'b1;
    ex_if.alu_op = 3'b010;
    ex_if.op_a   = 32'd1;
    ex_if.op_b   = 32'd2;
    @(posedge clk);
    #1;
    ex_if.start = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("abort_pre_busy", ex_if.busy, 1);
    ex_if.abort  = 1'b1;
    ex_if.start  = 1'b1;
    ex_if.alu_op = 3'b000;
    @(posedge clk);
    #1;
    ex_if.abort = 1'b0;
    ex_if.start = 1'b0;
    chk("abort_busy", ex_if.busy, 0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (ex_if.done || ex_if.busy) seen = 1;
    end
    chk("abort_no_done", seen, 0);
    chk("abort_res", ex_if.result, 32'hFFF0_FFF0);
    chk("abort_zero", ex_if.zero, 0);
    $display("op abort at cnt=20 -> result=%h", ex_if.result);

    run_op("illegal", 3'b011, 32'h1234_5678, 32'h1, 32'h0, 0, 1, 1, 0, 0);
    run_op("start_in_run", 3'b010, 32'd3, 32'd4, 32'd7, 0, 0, 32, 0, 5);
    run_op("start_abort_idle", 3'b010, 32'd100, 32'd200, 32'd300, 0, 0, 32, 1, 0);

    // Back-to-back with start held high: second accept in the IDLE after done
    @(negedge clk);
    ex_if.start  = 1'b1;
    ex_if.alu_op = 3'b010;
    ex_if.op_a   = 32'd10;
    ex_if.op_b   = 32'd20;
    @(posedge clk);
    n = 0;
    first_done = -1;
    second_done = -1;
    while (second_done < 0 && n < 200) begin
      @(posedge clk);
      n++;
      #1;
      if (ex_if.done) begin
        if (first_done < 0) first_done = n;
        else second_done = n;
      end
    end
    ex_if.start = 1'b0;
    chk("b2b_first", first_done, 32);
    chk("b2b_second", second_done, 66);
    chk("b2b_res", ex_if.result, 32'd30);
    $display("op back-to-back -> done at %0d and %0d, result=%h", first_done, second_done, ex_if.result);
    @(posedge clk);

    // Asynchronous reset at cnt=10
    @(negedge clk);
    ex_if.start  = 1'b1;
    ex_if.alu_op = 3'b010;
    ex_if.op_a   = 32'd5;
    ex_if.op_b   = 32'd6;
    @(posedge clk);
    #1;
    ex_if.start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("rst_mid_pre_busy", ex_if.busy, 1);
    rst = 1'b1;
    #1;
    chk_reset_vals("rst_mid");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (ex_if.done || ex_if.busy) seen = 1;
    end
    chk("rst_mid_no_done", seen, 0);
    $display("op reset at cnt=10 -> result=%h", ex_if.result);

    run_op("after_rst", 3'b000, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0F0F_0000, 0, 0, 32, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
